// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one single-ported memory among fetch, data and graphics.
// Fetch gets starvation protection, graphics locked bursts are bounded, and read data returns through a tag pipeline.
module mem_port_arbiter #(
   parameter int RD_LATENCY = 1,
   parameter int STARVE_MAX = 4,
   parameter int BURST_MAX  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   input  logic        g_req,
   input  logic [31:0] g_addr,
   input  logic [3:0]  g_we,
   input  logic [31:0] g_wdata,
   input  logic        g_lock,
   output logic        g_gnt,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic        mem_re,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout,
   output logic        cpu_stall
);

   typedef enum logic [1:0] {ARB, GLOCK, GCOOL} state_t;

   state_t      state_reg;
   logic [3:0]  starve_cnt_reg;
   logic [4:0]  beat_cnt_reg;
   logic        starved;
   logic [1:0]  tag_out;

   assign starved = (starve_cnt_reg == 4'(STARVE_MAX));

   // Graphics may only win in ARB; GCOOL reuses ARB ordering without it.
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      g_gnt = 1'b0;
      if (!rst) begin
         if (state_reg == GLOCK) begin
            g_gnt = g_req;
         end else if (starved) begin
            if (i_req)                        i_gnt = 1'b1;
            else if (d_req)                   d_gnt = 1'b1;
            else if (g_req && state_reg == ARB) g_gnt = 1'b1;
         end else begin
            if (d_req)                        d_gnt = 1'b1;
            else if (g_req && state_reg == ARB) g_gnt = 1'b1;
            else if (i_req)                   i_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      mem_addr = 32'h0;
      mem_we   = 4'h0;
      mem_din  = 32'h0;
      if (i_gnt) begin
         mem_addr = i_addr;
      end else if (d_gnt) begin
         mem_addr = d_addr;
         mem_we   = d_we;
         mem_din  = d_wdata;
      end else if (g_gnt) begin
         mem_addr = g_addr;
         mem_we   = g_we;
         mem_din  = g_wdata;
      end
   end

   assign mem_re    = i_gnt | (d_gnt & (d_we == 4'h0));
   assign cpu_stall = ~rst & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ARB;
         starve_cnt_reg <= 4'd0;
         beat_cnt_reg   <= 5'd0;
      end else begin
         if (i_req && !i_gnt) begin
            if (!starved) starve_cnt_reg <= starve_cnt_reg + 4'd1;
         end else begin
            starve_cnt_reg <= 4'd0;
         end

         case (state_reg)
            ARB: begin
               if (g_gnt && g_lock) begin
                  state_reg    <= GLOCK;
                  beat_cnt_reg <= 5'd1;
               end
            end
            GLOCK: begin
               if (!g_req) begin
                  state_reg <= ARB;
               end else begin
                  beat_cnt_reg <= beat_cnt_reg + 5'd1;
                  // A beat that releases the lock wins over reaching the burst limit.
                  if (!g_lock)
                     state_reg <= ARB;
                  else if (beat_cnt_reg + 5'd1 == 5'(BURST_MAX))
                     state_reg <= GCOOL;
               end
            end
            default: state_reg <= ARB;
         endcase
      end
   end

   // Tag stage holds {valid, is_fetch}; the last stage lines up with mem_dout.
   generate
      for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : gen_tag
         logic [1:0] stage_reg;
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst) stage_reg <= 2'b00;
               else     stage_reg <= {mem_re, i_gnt};
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (rst) stage_reg <= 2'b00;
               else     stage_reg <= gen_tag[gi-1].stage_reg;
            end
         end
      end
   endgenerate

   assign tag_out  = gen_tag[RD_LATENCY-1].stage_reg;
   assign i_rvalid = ~rst & tag_out[1] & tag_out[0];
   assign d_rvalid = ~rst & tag_out[1] & ~tag_out[0];
   assign i_rdata  = mem_dout;
   assign d_rdata  = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed grant sequences with a read-return scoreboard
// fed by a fixed-latency backend model.
module tb_mem_port_arbiter;

   localparam int RDL = 3;
   localparam logic [31:0] KEY = 32'hDEADBFEF;   // backend data = addr ^ KEY, so 0x100 -> 0xDEADBEEF

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, g_req, g_lock;
   logic [31:0] i_addr, d_addr, d_wdata, g_addr, g_wdata;
   logic [3:0]  d_we, g_we;
   logic        i_gnt, d_gnt, g_gnt, i_rvalid, d_rvalid, mem_re, cpu_stall;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;
   logic [3:0]  mem_we;

   mem_port_arbiter #(.RD_LATENCY(RDL), .STARVE_MAX(4), .BURST_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .g_req(g_req), .g_addr(g_addr), .g_we(g_we), .g_wdata(g_wdata), .g_lock(g_lock), .g_gnt(g_gnt),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_din(mem_din),
      .mem_dout(mem_dout), .cpu_stall(cpu_stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Backend: data for a read strobe appears RDL cycles later.
   logic [31:0] rd_pipe [RDL];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_re ? (mem_addr ^ KEY) : 32'h0;
      for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_dout = rd_pipe[RDL-1];

   typedef struct {
      bit          is_fetch;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   int errs   = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      i_req = 0; d_req = 0; g_req = 0; g_lock = 0; d_we = 4'h0; g_we = 4'h0;
      i_addr = 0; d_addr = 0; d_wdata = 0; g_addr = 0; g_wdata = 0;
   endtask

   task automatic push_rd(input bit f, input logic [31:0] a);
      exp_t e;
      e.is_fetch = f;
      e.data     = a ^ KEY;
      e.due      = cyc + RDL;
      sb.push_back(e);
      $display("push %s read addr=%08h due=%0d", f ? "fetch" : "data", a, e.due);
   endtask

   task automatic check_gnt(input string tag, input bit ei, input bit ed, input bit eg);
      check_eq(tag, {61'h0, i_gnt, d_gnt, g_gnt}, {61'h0, ei, ed, eg});
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_ctl"}, {i_gnt, d_gnt, g_gnt, mem_re, mem_we, cpu_stall, i_rvalid, d_rvalid}, 64'h0);
      check_eq({tag, "_addr"}, mem_addr, 64'h0);
      check_eq({tag, "_din"}, mem_din, 64'h0);
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 12 && sb.size() > 0; n++) tick();
      check_eq(tag, sb.size(), 0);
   endtask

   // Read-return scoreboard.
   always @(negedge clk) begin
      if (i_rvalid || d_rvalid) begin
         exp_t e;
         check_eq("rv_excl", {63'h0, i_rvalid & d_rvalid}, 64'h0);
         if (sb.size() == 0) begin
            check_eq("rv_unexpected", {62'h0, i_rvalid, d_rvalid}, 64'h0);
         end else begin
            e = sb.pop_front();
            check_eq("rv_src", {63'h0, i_rvalid}, {63'h0, e.is_fetch});
            check_eq("rv_data", i_rvalid ? i_rdata : d_rdata, e.data);
            check_eq("rv_cycle", cyc, e.due);
            $display("rvalid %s data=%08h cycle=%0d", i_rvalid ? "fetch" : "data",
                     i_rvalid ? i_rdata : d_rdata, cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset with every requester active: all outputs must be 0.
      idle();
      rst = 1; i_req = 1; d_req = 1; g_req = 1; g_lock = 1; d_we = 4'hF; g_we = 4'hF;
      d_addr = 32'h44; g_addr = 32'h88; d_wdata = 32'h55; g_wdata = 32'h66;
      tick(); settle(); check_zero("rst0");
      tick(); settle(); check_zero("rst1");
      tick(); rst = 0; idle();

      // Lone fetch.
      tick(); i_req = 1; i_addr = 32'h100; settle();
      check_gnt("f1_gnt", 1, 0, 0);
      check_eq("f1_re", {63'h0, mem_re}, 64'h1);
      check_eq("f1_addr", mem_addr, 32'h100);
      check_eq("f1_we", mem_we, 4'h0);
      check_eq("f1_stall", {63'h0, cpu_stall}, 64'h0);
      push_rd(1, 32'h100);
      for (int k = 0; k < 4; k++) begin
         tick(); idle(); settle();
         check_eq("f1_stall_after", {63'h0, cpu_stall}, 64'h0);
      end
      drain("f1_drain");

      // Fetch and data store together: data first, fetch next cycle.
      tick(); i_req = 1; i_addr = 32'h104; d_req = 1; d_we = 4'hF; d_addr = 32'h200; d_wdata = 32'h12345678;
      settle();
      check_gnt("c2_gnt0", 0, 1, 0);
      check_eq("c2_we", mem_we, 4'hF);
      check_eq("c2_addr", mem_addr, 32'h200);
      check_eq("c2_din", mem_din, 32'h12345678);
      check_eq("c2_re", {63'h0, mem_re}, 64'h0);
      check_eq("c2_stall0", {63'h0, cpu_stall}, 64'h1);
      tick(); d_req = 0; d_we = 4'h0; settle();
      check_gnt("c2_gnt1", 1, 0, 0);
      check_eq("c2_stall1", {63'h0, cpu_stall}, 64'h0);
      push_rd(1, 32'h104);
      tick(); idle();
      drain("c2_drain");

      // Starvation: data stores every cycle, fetch wins every fifth cycle.
      for (int k = 1; k <= 10; k++) begin
         tick();
         i_req = 1; i_addr = 32'h600 + 32'(4 * k);
         d_req = 1; d_we = 4'hF; d_addr = 32'h700; d_wdata = 32'(k);
         settle();
         check_gnt($sformatf("starve_gnt%0d", k), (k == 5 || k == 10), !(k == 5 || k == 10), 0);
         check_eq($sformatf("starve_stall%0d", k), {63'h0, cpu_stall}, 64'h1);
         if (k == 5 || k == 10) push_rd(1, i_addr);
      end
      tick(); idle();
      drain("starve_drain");

      // Locked graphics burst, data joins at beat 2 and wins the cool-down cycle.
      for (int k = 1; k <= 10; k++) begin
         tick();
         g_req = 1; g_addr = 32'h800 + 32'(4 * k); g_we = 4'hF; g_wdata = 32'(k); g_lock = (k < 10);
         d_req = (k >= 2 && k <= 9); d_we = 4'hF; d_addr = 32'h900; d_wdata = 32'hABCD;
         settle();
         check_gnt($sformatf("burst_gnt%0d", k), 0, (k == 9), (k <= 8 || k == 10));
         check_eq($sformatf("burst_addr%0d", k), mem_addr, (k == 9) ? 32'h900 : g_addr);
         check_eq($sformatf("burst_stall%0d", k), {63'h0, cpu_stall}, {63'h0, (k >= 2 && k <= 8)});
      end
      tick(); idle();

      // Two data reads then a fetch read, returned in order.
      tick(); d_req = 1; d_we = 4'h0; d_addr = 32'h300; settle();
      check_gnt("rd_gnt0", 0, 1, 0); push_rd(0, 32'h300);
      tick(); d_addr = 32'h304; settle();
      check_gnt("rd_gnt1", 0, 1, 0); push_rd(0, 32'h304);
      tick(); d_req = 0; i_req = 1; i_addr = 32'h400; settle();
      check_gnt("rd_gnt2", 1, 0, 0); push_rd(1, 32'h400);
      tick(); idle();
      drain("rd_drain");

      // Reset during a graphics lock with two reads in flight.
      tick(); d_req = 1; d_we = 4'h0; d_addr = 32'h500; settle();
      check_gnt("rr_gnt0", 0, 1, 0);
      tick(); d_req = 0; i_req = 1; i_addr = 32'h504; settle();
      check_gnt("rr_gnt1", 1, 0, 0);
      tick(); i_req = 0; g_req = 1; g_lock = 1; g_we = 4'hF; g_addr = 32'hA00; settle();
      check_gnt("rr_gnt2", 0, 0, 1);
      tick(); rst = 1; i_req = 1; i_addr = 32'h508; d_req = 1; d_addr = 32'h510; settle();
      check_zero("rr_rst0");
      tick(); settle();
      check_zero("rr_rst1");
      tick(); rst = 0; settle();
      check_gnt("rr_after", 0, 1, 0);
      push_rd(0, 32'h510);
      tick(); idle();
      drain("rr_drain");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
